// File: rtl/mbox_req_seq_if.sv
// mbox_req_seq_if -- bundle of every handshake/bus signal of mbox_req_seq.
//
// EBOX side:
//   EBOX_REQ        request strobe
//   EBOX_VMA        request address [13:35]
//   eboxRead/Write  request type (both set is a read)
//   cacheDataWrite  store data [0:35]
//   mboxRespIn      one-cycle completion pulse
//   cacheDataRead   load data returned [0:35]
//   nxmErr          one-cycle nonexistent-memory pulse
//   busy            sequencer not idle
// Memory backend side:
//   memReq          backend request
//   memAdr          backend address [13:35]
//   memRead/Write   backend request type
//   memWrData       backend store data [0:35]
//   memAck          backend accept/complete
//   memRdData       backend load data [0:35], valid with memAck
//
// Modports: master = the sequencer, slave = the EBOX/backend environment.
interface mbox_req_seq_if;
  logic        EBOX_REQ;
  logic [13:35] EBOX_VMA;
  logic        eboxRead;
  logic        eboxWrite;
  logic [0:35] cacheDataWrite;

  logic        memReq;
  logic [13:35] memAdr;
  logic        memRead;
  logic        memWrite;
  logic [0:35] memWrData;
  logic        memAck;
  logic [0:35] memRdData;

  logic        mboxRespIn;
  logic [0:35] cacheDataRead;
  logic        nxmErr;
  logic        busy;

  modport master (
    input  EBOX_REQ, EBOX_VMA, eboxRead, eboxWrite, cacheDataWrite,
    input  memAck, memRdData,
    output memReq, memAdr, memRead, memWrite, memWrData,
    output mboxRespIn, cacheDataRead, nxmErr, busy
  );

  modport slave (
    output EBOX_REQ, EBOX_VMA, eboxRead, eboxWrite, cacheDataWrite,
    output memAck, memRdData,
    input  memReq, memAdr, memRead, memWrite, memWrData,
    input  mboxRespIn, cacheDataRead, nxmErr, busy
  );
endinterface

// File: rtl/mbox_req_seq.sv
// mbox_req_seq -- single-outstanding EBOX memory request sequencer.
//
// Accepts one EBOX request while idle, presents it to the memory backend
// until memAck, then pulses mboxRespIn for one cycle. Requests arriving
// while busy are dropped (no queueing).
//
// Ports:
//   clk     system clock
//   CROBAR  synchronous active-high reset
//   bus     mbox_req_seq_if.master (EBOX and backend signals)
//
// Parameter:
//   TIMEOUT_CYCLES  REQ cycles without memAck before NXM (2..255)
//
// Build option:
//   MBOX_TIMEOUT_EN  when defined, an 8-bit REQ-cycle counter ends a request
//                    after TIMEOUT_CYCLES with nxmErr; otherwise REQ waits
//                    for memAck forever and nxmErr is tied low.
module mbox_req_seq #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic           clk,
  input  logic           CROBAR,
  mbox_req_seq_if.master bus
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : gBadTimeout
    $error("mbox_req_seq: TIMEOUT_CYCLES must be in 2..255");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } seqStateT;

  seqStateT     state;
  seqStateT     nextState;
  logic [13:35] adrLat;
  logic [0:35]  wrDataLat;
  logic         rdLat;
  logic [0:35]  cacheRd;
  logic         reqValid;
  logic         timeoutHit;

  // Both type bits set is a read; neither set is not a request at all.
  assign reqValid = bus.EBOX_REQ && (bus.eboxRead || bus.eboxWrite);

`ifdef MBOX_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] toCnt;
  logic       nxmNext;
  logic       nxmLat;

  // Counts REQ cycles already spent without memAck. The cycle in which the
  // count would reach TIMEOUT_CYCLES is the last REQ cycle.
  always_ff @(posedge clk) begin
    if (CROBAR) begin
      toCnt <= '0;
    end else if (state != REQ) begin
      toCnt <= '0;
    end else if (!bus.memAck) begin
      toCnt <= toCnt + 8'd1;
    end
  end

  assign timeoutHit = (toCnt == TO_LAST);
`else
  assign timeoutHit = 1'b0;
`endif

  // NOTE: state and datapath registers use non-blocking assignments so every
  // flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    // NOTE: address/data latches are reset too, because the reset values of
    // memAdr, memWrData and cacheDataRead are architecturally visible.
    if (CROBAR) begin
      state     <= IDLE;
      adrLat    <= '0;
      wrDataLat <= '0;
      rdLat     <= 1'b0;
      cacheRd   <= '0;
    end else begin
      state <= nextState;
      if (state == IDLE && reqValid) begin
        adrLat    <= bus.EBOX_VMA;
        wrDataLat <= bus.cacheDataWrite;
        rdLat     <= bus.eboxRead;
      end
      if (state == REQ && rdLat) begin
        if (bus.memAck) begin
          cacheRd <= bus.memRdData;
        end else if (timeoutHit) begin
          cacheRd <= '0;
        end
      end
    end
  end

  // NOTE: every signal written here gets a default first so no path through
  // the case statement can infer a latch.
  always_comb begin
    nextState = state;
`ifdef MBOX_TIMEOUT_EN
    nxmNext   = 1'b0;
`endif
    case (state)
      IDLE: if (reqValid) nextState = REQ;
      REQ: begin
        // memAck wins over a timeout landing in the same cycle.
        if (bus.memAck) begin
          nextState = RESP;
        end else if (timeoutHit) begin
          nextState = RESP;
`ifdef MBOX_TIMEOUT_EN
          nxmNext   = 1'b1;
`endif
        end
      end
      RESP:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

`ifdef MBOX_TIMEOUT_EN
  // Registered so nxmErr lines up with the RESP cycle (mboxRespIn).
  always_ff @(posedge clk) begin
    if (CROBAR) begin
      nxmLat <= 1'b0;
    end else begin
      nxmLat <= nxmNext;
    end
  end

  assign bus.nxmErr = nxmLat;
`else
  assign bus.nxmErr = 1'b0;
`endif

  assign bus.memReq        = (state == REQ);
  assign bus.memRead       = (state == REQ) && rdLat;
  assign bus.memWrite      = (state == REQ) && !rdLat;
  assign bus.memAdr        = adrLat;
  assign bus.memWrData     = wrDataLat;
  assign bus.mboxRespIn    = (state == RESP);
  assign bus.cacheDataRead = cacheRd;
  assign bus.busy          = (state != IDLE);

endmodule

// File: tb/tb_mbox_req_seq.sv
// tb_mbox_req_seq -- self-checking bench for mbox_req_seq.
//
// Each transaction is described by its request fields and by how many REQ
// cycles pass before memAck. Expected behaviour is derived arithmetically:
// memReq stays up for min(ackDelay+1, TIMEOUT) cycles (timeout only when
// MBOX_TIMEOUT_EN is defined), then one response cycle follows, and the
// returned load data is remembered across writes.
module tb_mbox_req_seq;

  localparam int TO = 64;

`ifdef MBOX_TIMEOUT_EN
  localparam bit TO_ON = 1'b1;
`else
  localparam bit TO_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic CROBAR;

  always #5 clk = ~clk;

  mbox_req_seq_if bus ();

  mbox_req_seq #(.TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .CROBAR(CROBAR),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [0:35] expCache;

  task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0o expected=%0o", tag, obs, exp);
    end
  endtask

  function automatic logic [0:35] rnd36();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[35:0];
  endfunction

  task automatic quietInputs();
    bus.EBOX_REQ       = 1'b0;
    bus.eboxRead       = 1'b0;
    bus.eboxWrite      = 1'b0;
    bus.EBOX_VMA       = 23'($urandom);
    bus.cacheDataWrite = rnd36();
    bus.memAck         = 1'b0;
    bus.memRdData      = rnd36();
  endtask

  // Drives one request from IDLE and checks every cycle until back in IDLE.
  // poke keeps hammering EBOX_REQ with a different request while busy.
  task automatic runTxn(input bit rd, input bit wr, input logic [13:35] adr,
                        input logic [0:35] wd, input logic [0:35] rdat,
                        input int d, input bit poke);
    bit isRead;
    int reqLen;
    bit nxm;
    isRead = rd;
    if (TO_ON && (d + 1 > TO)) begin
      reqLen = TO;
      nxm    = 1'b1;
    end else begin
      reqLen = d + 1;
      nxm    = 1'b0;
    end

    check("idle_busy", bus.busy, 0);
    bus.EBOX_REQ       = 1'b1;
    bus.eboxRead       = rd;
    bus.eboxWrite      = wr;
    bus.EBOX_VMA       = adr;
    bus.cacheDataWrite = wd;
    bus.memAck         = 1'($urandom_range(0, 1));
    bus.memRdData      = rnd36();
    @(negedge clk);

    for (int i = 1; i <= reqLen; i++) begin
      check("req_memReq", bus.memReq, 1);
      check("req_memAdr", bus.memAdr, adr);
      check("req_memRead", bus.memRead, isRead);
      check("req_memWrite", bus.memWrite, !isRead);
      check("req_memWrData", bus.memWrData, wd);
      check("req_busy", bus.busy, 1);
      check("req_resp", bus.mboxRespIn, 0);
      check("req_nxm", bus.nxmErr, 0);
      if (poke) begin
        bus.EBOX_REQ       = 1'b1;
        bus.eboxRead       = 1'b1;
        bus.eboxWrite      = 1'b0;
        bus.EBOX_VMA       = ~adr;
        bus.cacheDataWrite = ~wd;
      end else begin
        bus.EBOX_REQ  = 1'b0;
        bus.eboxRead  = 1'b0;
        bus.eboxWrite = 1'b0;
      end
      bus.memAck    = (i == d + 1);
      bus.memRdData = (i == d + 1) ? rdat : rnd36();
      @(negedge clk);
    end

    if (isRead) expCache = nxm ? 36'd0 : rdat;
    check("resp_memReq", bus.memReq, 0);
    check("resp_pulse", bus.mboxRespIn, 1);
    check("resp_nxm", bus.nxmErr, nxm);
    check("resp_busy", bus.busy, 1);
    check("resp_cacheRd", bus.cacheDataRead, expCache);
    // Stray ack and (optionally) a new request during RESP must be ignored.
    bus.EBOX_REQ  = poke;
    bus.eboxRead  = poke;
    bus.memAck    = 1'b1;
    bus.memRdData = rnd36();
    @(negedge clk);

    check("post_pulse", bus.mboxRespIn, 0);
    check("post_busy", bus.busy, 0);
    check("post_memReq", bus.memReq, 0);
    check("post_nxm", bus.nxmErr, 0);
    check("post_cacheRd", bus.cacheDataRead, expCache);
    // Late memAck in IDLE has no effect.
    bus.EBOX_REQ  = 1'b0;
    bus.eboxRead  = 1'b0;
    bus.eboxWrite = 1'b0;
    bus.memAck    = 1'b1;
    bus.memRdData = rnd36();
    @(negedge clk);

    check("late_busy", bus.busy, 0);
    check("late_memReq", bus.memReq, 0);
    check("late_cacheRd", bus.cacheDataRead, expCache);
    quietInputs();
  endtask

  initial begin
    bit rd;
    bit wr;

    // Reset state.
    CROBAR = 1'b1;
    quietInputs();
    @(negedge clk);
    @(negedge clk);
    check("rst_memReq", bus.memReq, 0);
    check("rst_memRead", bus.memRead, 0);
    check("rst_memWrite", bus.memWrite, 0);
    check("rst_resp", bus.mboxRespIn, 0);
    check("rst_nxm", bus.nxmErr, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_memAdr", bus.memAdr, 0);
    check("rst_memWrData", bus.memWrData, 0);
    check("rst_cacheRd", bus.cacheDataRead, 0);
    expCache = '0;
    CROBAR = 1'b0;
    @(negedge clk);

    // Request with no type bit is ignored.
    bus.EBOX_REQ = 1'b1;
    @(negedge clk);
    check("notype_busy", bus.busy, 0);
    check("notype_memReq", bus.memReq, 0);
    quietInputs();
    @(negedge clk);

    // Read, ack on the first REQ cycle: pulse in the third cycle.
    runTxn(1'b1, 1'b0, 23'o1234, rnd36(), 36'o123456654321, 0, 1'b0);
    // Write, ack delayed 5 cycles: six stable REQ cycles, cache untouched.
    runTxn(1'b0, 1'b1, 23'o4321, 36'o777000111222, rnd36(), 5, 1'b0);
    // Requests while busy are dropped.
    runTxn(1'b1, 1'b0, 23'o7070, rnd36(), rnd36(), 3, 1'b1);
    // Both type bits set behaves as a read.
    runTxn(1'b1, 1'b1, 23'o5555, rnd36(), rnd36(), 1, 1'b0);
    // Ack on the 64th REQ cycle: normal completion even with timeout on.
    runTxn(1'b1, 1'b0, 23'o1111, rnd36(), rnd36(), TO - 1, 1'b0);
    // No ack for a long time: timeout when enabled, otherwise keeps waiting.
    runTxn(1'b1, 1'b0, 23'o2222, rnd36(), rnd36(), 80, 1'b0);
    runTxn(1'b0, 1'b1, 23'o3333, rnd36(), rnd36(), 70, 1'b0);

    // Randomized transactions.
    for (int n = 0; n < 12; n++) begin
      rd = 1'($urandom_range(0, 1));
      wr = rd ? 1'($urandom_range(0, 1)) : 1'b1;
      runTxn(rd, wr, 23'($urandom), rnd36(), rnd36(),
             int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    end

    // Reset two cycles into REQ, with an ack that would otherwise complete.
    bus.EBOX_REQ       = 1'b1;
    bus.eboxRead       = 1'b1;
    bus.EBOX_VMA       = 23'o6543;
    bus.cacheDataWrite = rnd36();
    @(negedge clk);
    quietInputs();
    check("rstreq_memReq1", bus.memReq, 1);
    @(negedge clk);
    check("rstreq_memReq2", bus.memReq, 1);
    CROBAR        = 1'b1;
    bus.memAck    = 1'b1;
    bus.memRdData = rnd36();
    @(negedge clk);
    expCache = '0;
    check("rstreq_memReq", bus.memReq, 0);
    check("rstreq_busy", bus.busy, 0);
    check("rstreq_resp", bus.mboxRespIn, 0);
    check("rstreq_cacheRd", bus.cacheDataRead, expCache);
    CROBAR = 1'b0;
    quietInputs();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rstreq_noresp", bus.mboxRespIn, 0);
      check("rstreq_idle", bus.busy, 0);
    end

    // Normal operation resumes after reset.
    runTxn(1'b1, 1'b0, 23'o17, rnd36(), rnd36(), 2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mbox_req_seq.md
MBOX_REQ_SEQ -- requirements
Module: mbox_req_seq

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, meaning cycles of memReq without memAck before NXM; legal range 2..255.
REQ-002 SHALL have port clk, input, 1, the single system clock.
REQ-003 SHALL have port CROBAR, input, 1, reset, synchronous and active-high.
REQ-004 SHALL have port EBOX_REQ, input, 1, EBOX memory request strobe.
REQ-005 SHALL have port EBOX_VMA, input, [13:35], request address.
REQ-006 SHALL have ports eboxRead and eboxWrite, each input, 1, request type.
REQ-007 SHALL have port cacheDataWrite, input, [0:35], EBOX store data.
REQ-008 SHALL have port memReq, output, 1, backend request.
REQ-009 SHALL have port memAdr, output, [13:35], backend address.
REQ-010 SHALL have ports memRead and memWrite, each output, 1, backend request type.
REQ-011 SHALL have port memWrData, output, [0:35], backend store data.
REQ-012 SHALL have port memAck, input, 1, backend accept/complete.
REQ-013 SHALL have port memRdData, input, [0:35], backend load data, valid with memAck.
REQ-014 SHALL have port mboxRespIn, output, 1, one-cycle completion pulse to EBOX.
REQ-015 SHALL have port cacheDataRead, output, [0:35], load data returned to EBOX.
REQ-016 SHALL have port nxmErr, output, 1, one-cycle nonexistent-memory pulse.
REQ-017 SHALL have port busy, output, 1, high whenever state is not IDLE.

Function
REQ-018 SHALL implement FSM states IDLE, REQ, RESP.
REQ-019 In IDLE, EBOX_REQ with eboxRead or eboxWrite set SHALL latch EBOX_VMA, type and cacheDataWrite, then enter REQ next cycle.
REQ-020 EBOX_REQ with neither eboxRead nor eboxWrite SHALL be ignored.
REQ-021 eboxRead and eboxWrite both set SHALL be treated as a read.
REQ-022 In REQ, memReq SHALL be 1 and memAdr, memRead, memWrite, memWrData SHALL hold the latched values stable until the cycle memAck is sampled high.
REQ-023 memAck sampled high in REQ, including on REQ's first cycle, SHALL enter RESP. On a read, memRdData SHALL be captured into cacheDataRead.
REQ-024 In RESP, mboxRespIn SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-025 Minimum latency SHALL be 3 cycles from EBOX_REQ sampled to the mboxRespIn pulse.
REQ-026 EBOX_REQ while busy SHALL be ignored; there is no queueing.
REQ-027 memAck outside REQ SHALL be ignored.
REQ-028 cacheDataRead SHALL hold its value until the next read completion, and SHALL be unchanged by writes.
REQ-029 memReq SHALL be 0 in IDLE and RESP.

Reset
REQ-030 CROBAR high at a clock edge SHALL force IDLE regardless of state, including mid-request.
REQ-031 On reset, memReq, memRead, memWrite, mboxRespIn, nxmErr and busy SHALL be 0, and memAdr, memWrData and cacheDataRead SHALL be 0.
REQ-032 A request interrupted by reset SHALL produce no mboxRespIn.

Configuration
REQ-033 With MBOX_TIMEOUT_EN defined, an 8-bit counter SHALL clear on entry to REQ and increment each REQ cycle without memAck.
REQ-034 With MBOX_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES the block SHALL drop memReq, zero cacheDataRead on a read, and enter RESP with nxmErr pulsed together with mboxRespIn.
REQ-035 memAck in the same cycle the timeout is reached SHALL win: normal completion, no nxmErr.
REQ-036 Without MBOX_TIMEOUT_EN, REQ SHALL wait indefinitely, nxmErr SHALL be tied 0, and no counter SHALL be present.

Verification
REQ-037 Read test: VMA=0o1234, eboxRead, memAck in the first REQ cycle with memRdData=0o123456654321 -> mboxRespIn 3 cycles after the request, cacheDataRead=0o123456654321.
REQ-038 Write test: eboxWrite, cacheDataWrite=0o777000111222, memAck delayed 5 cycles -> memWrData stable for all 6 REQ cycles, one mboxRespIn pulse, cacheDataRead unchanged.
REQ-039 Busy test: a second EBOX_REQ issued while in REQ -> ignored; exactly one memReq transaction.
REQ-040 Timeout test (macro on, TIMEOUT_CYCLES=64): no memAck -> memReq drops after 64 cycles, nxmErr and mboxRespIn pulse together, cacheDataRead=0; a late memAck in IDLE has no effect.
REQ-041 Reset test: CROBAR asserted 2 cycles into REQ -> memReq 0 and busy 0 the next cycle, no mboxRespIn.
REQ-042 Tie test: memAck arrives exactly on the timeout cycle -> normal completion with nxmErr=0.
